// File: rtl/rx_word_packer_pkg.sv
// Shared word/byte types for the UART receive word packer.
package rx_pkg;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef logic [1:0]        byte_idx_t;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/rx_word_packer_fifo.sv
// word_fifo: small synchronous FIFO with a flop-array head read and sync flush.
module word_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic [WIDTH-1:0]      head
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [DEPTH_LOG2-1:0]       wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]         cnt;
   logic                        do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push & (~full | do_pop);
   assign level   = cnt;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/rx_word_packer.sv
// Packs UART bytes little-endian into 32-bit words and queues them for the loader.
// Build option RX_PACK_ERR_DROP_EN: discard a byte with a fresh framing error and restart the word.
module rx_word_packer
   import rx_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   input  logic                  rx_ferr,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic [WORD_W-1:0]     word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ferr_seen,
   output logic                  overflow
);
   byte_idx_t byte_cnt;
   word_t     shift_q, shift_nxt;
   logic      ferr_prev, charged, drop_byte;
   logic      push, pop, ovf_evt;
   logic      fifo_empty, fifo_full;

   // rx_ferr is sticky upstream, so only its rising edge between strobes counts.
   assign charged = rx_ready & rx_ferr & ~ferr_prev;

`ifdef RX_PACK_ERR_DROP_EN
   assign drop_byte = charged;
`else
   assign drop_byte = 1'b0;
`endif

   always_comb begin
      shift_nxt = shift_q;
      shift_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
   end

   assign push    = rx_ready & ~flush & ~drop_byte & (byte_cnt == 2'd3);
   assign pop     = word_valid & word_ready;
   assign ovf_evt = push & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byte_cnt  <= '0;
         shift_q   <= '0;
         ferr_prev <= 1'b0;
         ferr_seen <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (rx_ready)
            ferr_prev <= rx_ferr;

         if (flush) begin
            byte_cnt <= '0;
            shift_q  <= '0;
         end else if (rx_ready) begin
            if (drop_byte || byte_cnt == 2'd3) begin
               byte_cnt <= '0;
               shift_q  <= '0;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
               shift_q  <= shift_nxt;
            end
         end

         // New events beat a same-cycle clear.
         if (charged)      ferr_seen <= 1'b1;
         else if (err_clr) ferr_seen <= 1'b0;
         if (ovf_evt)      overflow  <= 1'b1;
         else if (err_clr) overflow  <= 1'b0;
      end
   end

   word_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (shift_nxt),
      .pop       (pop),
      .flush     (flush),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (level),
      .head      (word_data)
   );

   assign word_valid = ~fifo_empty;
endmodule

// File: tb/tb_rx_word_packer.sv
// Scoreboard bench for rx_word_packer (DEPTH_LOG2=2); honours RX_PACK_ERR_DROP_EN.
module tb_rx_word_packer;
   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  rx_data;
   logic        rx_ready, rx_ferr, flush, err_clr, word_ready;
   logic [31:0] word_data;
   logic        word_valid, ferr_seen, overflow;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   rx_word_packer #(.DEPTH_LOG2(2)) dut (
      .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_ready(rx_ready),
      .rx_ferr(rx_ferr), .flush(flush), .err_clr(err_clr),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .level(level), .ferr_seen(ferr_seen), .overflow(overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head word must match the scoreboard front.
   always @(negedge clk) begin
      if (rstn && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected got %h expected none", word_data);
         end else begin
            chk("pop_word", word_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic strobe(input logic [7:0] b, input logic fe);
      rx_data = b; rx_ferr = fe; rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) strobe(w[8*i +: 8], 1'b0);
   endtask

   task automatic drain(input int n);
      word_ready = 1'b1;
      repeat (n) tick();
      word_ready = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; rx_data = '0; rx_ready = 0; rx_ferr = 0;
      flush = 0; err_clr = 0; word_ready = 0;
      #12;
      chk("rst_valid", word_valid, 0);
      chk("rst_data", word_data, 0);
      chk("rst_level", level, 0);
      chk("rst_ferr", ferr_seen, 0);
      chk("rst_ovf", overflow, 0);
      rstn = 1'b1;
      tick();

      // 1: basic packing and one-cycle latency
      strobe(8'h11, 0); strobe(8'h22, 0); strobe(8'h33, 0);
      chk("t1_not_yet", word_valid, 0);
      exp_q.push_back(32'h44332211);
      strobe(8'h44, 0);
      chk("t1_valid", word_valid, 1);
      chk("t1_data", word_data, 32'h44332211);
      chk("t1_level", level, 1);
      drain(1);
      chk("t1_level0", level, 0);

      // 2: overflow drops the fifth word
      foreach (exp_q[i]) ;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A1A200 + i);
      for (int i = 0; i < 4; i++) send_word(32'hA0A1A200 + i);
      chk("t2_full_ovf0", overflow, 0);
      send_word(32'hDEADBEEF);
      chk("t2_level", level, 4);
      chk("t2_ovf", overflow, 1);
      chk("t2_head_stable", word_data, 32'hA0A1A200);
      drain(4);
      chk("t2_level0", level, 0);
      err_clr = 1; tick(); err_clr = 0;
      chk("t2_ovf_clr", overflow, 0);

      // 3: full with a simultaneous pop accepts the push
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hB0B1B200 + i);
      for (int i = 0; i < 4; i++) send_word(32'hB0B1B200 + i);
      exp_q.push_back(32'h0C0B0A09);
      strobe(8'h09, 0); strobe(8'h0A, 0); strobe(8'h0B, 0);
      rx_data = 8'h0C; rx_ready = 1; word_ready = 1;
      tick();
      rx_ready = 0; word_ready = 0;
      chk("t3_level", level, 4);
      chk("t3_ovf", overflow, 0);
      drain(4);
      chk("t3_level0", level, 0);

      // 4: framing error charged on rising edge of rx_ferr
`ifdef RX_PACK_ERR_DROP_EN
      exp_q.push_back(32'h01FFEEDD);
`else
      exp_q.push_back(32'hDDCCBBAA);
`endif
      strobe(8'hAA, 0); strobe(8'hBB, 0); strobe(8'hCC, 1);
      chk("t4_ferr", ferr_seen, 1);
      strobe(8'hDD, 1); strobe(8'hEE, 1); strobe(8'hFF, 1); strobe(8'h01, 1);
      chk("t4_ferr_hold", ferr_seen, 1);
      chk("t4_level", level, 1);
      drain(1);
      flush = 1; tick(); flush = 0;
      strobe(8'h00, 0);
      flush = 1; tick(); flush = 0;
      // clear loses to a same-cycle fresh error
      err_clr = 1; rx_data = 8'h00; rx_ferr = 1; rx_ready = 1; flush = 1;
      tick();
      err_clr = 0; rx_ready = 0; rx_ferr = 0; flush = 0;
      chk("t4_clr_loses", ferr_seen, 1);
      err_clr = 1; tick(); err_clr = 0;
      chk("t4_clr", ferr_seen, 0);
      chk("t4_level0", level, 0);

      // 5: flush abandons a partial word
      strobe(8'h00, 0);   // re-arm ferr edge tracker with rx_ferr low
      strobe(8'h55, 0); strobe(8'h66, 0);
      flush = 1; tick(); flush = 0;
      exp_q.push_back(32'h04030201);
      strobe(8'h01, 0); strobe(8'h02, 0); strobe(8'h03, 0); strobe(8'h04, 0);
      chk("t5_level", level, 1);
      chk("t5_data", word_data, 32'h04030201);
      drain(1);

      // 6: async reset mid-word with queued words
      send_word(32'h12345678); send_word(32'h9ABCDEF0);
      strobe(8'h77, 0); strobe(8'h88, 0);
      chk("t6_level_pre", level, 2);
      #2 rstn = 1'b0;
      #1;
      chk("t6_valid", word_valid, 0);
      chk("t6_level", level, 0);
      chk("t6_flags", {ferr_seen, overflow}, 0);
      @(negedge clk); rstn = 1'b1;
      tick();
      exp_q.push_back(32'h44332211);
      strobe(8'h11, 0); strobe(8'h22, 0); strobe(8'h33, 0); strobe(8'h44, 0);
      chk("t6_level1", level, 1);
      drain(1);
      chk("t6_level0", level, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
